// File: rtl/uart_pkg.sv
// Shared constants for the 8N1 UART receive path: state encoding and line-rate defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    localparam int CLK_FREQ_DEF = 50_000_000;
    localparam int BAUD_DEF     = 115_200;

    // Receiver FSM encoding; kept as plain constants so older tools and
    // waveform scripts that match on raw values keep working.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    // Integer cycles per bit; the fractional remainder is absorbed by
    // mid-bit sampling.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous level input, reset to RST_VAL.
// Latency: 2 clk edges from d to q.
// Backpressure: none; free-running.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised output).
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver feeding the hex loader through the dout/rdy/rdy_clr handshake.
// Latency: rdy rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT edges after the start edge.
// Backpressure: none on the line; an unacknowledged byte is overwritten and overrun is flagged.
// Ports: clk, rst_n, rx (async serial in), rdy_clr (ack pulse) ->
//        dout (last good byte), rdy / frame_err / overrun (sticky until rdy_clr), busy.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = CLK_FREQ_DEF,
    parameter int BAUD         = BAUD_DEF,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            dout      <= '0;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Acknowledge first; any flag set below in the same cycle
            // overrides it, so a completion racing rdy_clr is never lost.
            if (rdy_clr) begin
                rdy       <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end

                ST_START: begin
                    // Re-check the line at mid start bit; a short low pulse
                    // is treated as noise and dropped silently.
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            dout <= shift;
                            rdy  <= 1'b1;
                            // An ack arriving with the new byte retires the
                            // old one, so it is not an overrun.
                            if (rdy && !rdy_clr) begin
                                overrun <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_WAIT_IDLE: begin
                    // A held-low line (break) must not be mistaken for a
                    // stream of start bits.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rdy_clr;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_core #(
        .CLK_FREQ     (800),
        .BAUD         (100),
        .CLKS_PER_BIT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .dout      (dout),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       ov;
        logic       fe;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic       m_prdy = 1'b0;
    logic       m_pov  = 1'b0;
    logic [7:0] m_pd   = 8'h00;
    exp_t       m_e;
    int         hold_drops;
    int         busy_wait;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; each bit is held for 8 clocks. rx is left at
    // the stop-bit value.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (8) @(negedge clk);
        end
        rx = stop_bit;
        repeat (8) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk);
        rdy_clr = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        chk8("rst_dout", dout, 8'h00);
        chk1("rst_rdy", rdy, 1'b0);
        chk1("rst_frame_err", frame_err, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        idle(3);
        rst_n = 1'b1;
        idle(4);
    endtask

    // Edge 0 is the posedge right after rx is driven low; edge 77 waits
    // until just past edge 77.
    task automatic to_edge77();
        @(posedge clk);
        repeat (77) @(posedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        rx      = 1'b1;
        rdy_clr = 1'b0;
        fork
            begin : stimulus
                apply_reset();

                // 0x41: exact rdy latency, then rdy is sticky until acknowledged.
                sb_q.push_back(exp_t'{d: 8'h41, ov: 1'b0, fe: 1'b0});
                fork
                    send_byte(8'h41, 1'b1);
                    begin
                        to_edge77();
                        #1 chk1("lat_rdy_edge77", rdy, 1'b0);
                        @(posedge clk);
                        #1 chk1("lat_rdy_edge78", rdy, 1'b1);
                    end
                join
                hold_drops = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (!rdy) hold_drops++;
                end
                chk8("rdy_hold_50_drops", 8'(hold_drops), 8'd0);
                chk1("hold_frame_err", frame_err, 1'b0);
                pulse_clr();
                chk1("clr_rdy", rdy, 1'b0);

                // Three-cycle low glitch is rejected in START.
                rx = 1'b0;
                idle(3);
                rx = 1'b1;
                busy_wait = 0;
                while (busy && busy_wait < 8) begin
                    @(negedge clk);
                    busy_wait++;
                end
                chk1("glitch_busy", busy, 1'b0);
                idle(10);
                chk1("glitch_rdy", rdy, 1'b0);
                chk1("glitch_frame_err", frame_err, 1'b0);
                chk1("glitch_overrun", overrun, 1'b0);

                // Framing error with rdy_clr on the same edge, then a break.
                apply_reset();
                fork
                    send_byte(8'h55, 1'b0);
                    begin
                        to_edge77();
                        @(negedge clk);
                        rdy_clr = 1'b1;
                        @(negedge clk);
                        rdy_clr = 1'b0;
                        chk1("fe_set_wins", frame_err, 1'b1);
                    end
                join
                idle(40);
                chk1("fe_hold_frame_err", frame_err, 1'b1);
                chk1("fe_hold_rdy", rdy, 1'b0);
                chk8("fe_hold_dout", dout, 8'h00);
                chk1("fe_hold_busy", busy, 1'b1);
                rx = 1'b1;
                idle(4);
                chk1("fe_release_busy", busy, 1'b0);
                pulse_clr();
                chk1("fe_cleared", frame_err, 1'b0);
                sb_q.push_back(exp_t'{d: 8'h33, ov: 1'b0, fe: 1'b0});
                send_byte(8'h33, 1'b1);
                idle(4);
                chk8("after_fe_dout", dout, 8'h33);

                // 0x46 completes while 0x33 is still pending, acked on that edge.
                sb_q.push_back(exp_t'{d: 8'h46, ov: 1'b0, fe: 1'b0});
                fork
                    send_byte(8'h46, 1'b1);
                    begin
                        to_edge77();
                        @(negedge clk);
                        rdy_clr = 1'b1;
                        @(negedge clk);
                        rdy_clr = 1'b0;
                        chk1("race_rdy", rdy, 1'b1);
                        chk8("race_dout", dout, 8'h46);
                        chk1("race_overrun", overrun, 1'b0);
                    end
                join
                idle(4);

                // Back-to-back 0x31, 0x32 without acknowledgement.
                pulse_clr();
                sb_q.push_back(exp_t'{d: 8'h31, ov: 1'b0, fe: 1'b0});
                sb_q.push_back(exp_t'{d: 8'h32, ov: 1'b1, fe: 1'b0});
                send_byte(8'h31, 1'b1);
                send_byte(8'h32, 1'b1);
                idle(4);
                chk8("ovr_dout", dout, 8'h32);
                chk1("ovr_rdy", rdy, 1'b1);
                chk1("ovr_overrun", overrun, 1'b1);
                pulse_clr();
                chk1("ovr_clr_rdy", rdy, 1'b0);
                chk1("ovr_clr_overrun", overrun, 1'b0);
                chk1("ovr_clr_frame_err", frame_err, 1'b0);

                // Reset after bit 3 of 0xA5, then a clean 0x30.
                rx = 1'b0;
                idle(8);
                rx = 1'b1; idle(8);
                rx = 1'b0; idle(8);
                rx = 1'b1; idle(8);
                rx = 1'b0; idle(8);
                apply_reset();
                idle(20);
                chk1("post_rst_no_rdy", rdy, 1'b0);
                sb_q.push_back(exp_t'{d: 8'h30, ov: 1'b0, fe: 1'b0});
                send_byte(8'h30, 1'b1);
                idle(10);
                chk1("post_rst_rdy", rdy, 1'b1);
                chk8("post_rst_dout", dout, 8'h30);
                chk1("post_rst_overrun", overrun, 1'b0);

                n_cmp++;
                if (sb_q.size() != 0) begin
                    n_err++;
                    $display("FAIL sb_drain: %0d expected bytes never presented, required 0", sb_q.size());
                end
            end

            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst_n && rdy && (!m_prdy || dout != m_pd || (overrun && !m_pov))) begin
                        if (sb_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL mon_unexpected: byte 0x%02h presented, none expected", dout);
                        end else begin
                            m_e = sb_q.pop_front();
                            chk8("mon_dout", dout, m_e.d);
                            chk1("mon_overrun", overrun, m_e.ov);
                            chk1("mon_frame_err", frame_err, m_e.fe);
                        end
                    end
                    m_prdy = rdy;
                    m_pov  = overrun;
                    m_pd   = dout;
                end
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
